kf_bram_responder: RTL and testbench
====================================

// Module: kf_bram_responder
// PURPOSE
//  Block-RAM-backed responder for the KFSDRAM request/flag/idle access protocol.
//  Drop-in target for the RAM bridge's SDRAM-controller port, for builds/benches without external SDRAM.
//  Accepts single or burst word reads/writes.
//  Reproduces the controller's handshake timing (request -> latency -> flag burst -> recovery -> idle).
// PARAMETERS
//  MEM_ADDR_BITS   16  word-address bits implemented; depth = 2**MEM_ADDR_BITS x 16 bit
//  WRITE_LATENCY   2   cycles from request accept to first write_flag cycle (>=1)
//  READ_LATENCY    3   cycles from request accept to first read_flag cycle (>=2)
//  RECOVERY        2   cycles after last flag cycle before idle reasserts (>=1)
// PORTS
//  sdram_clock    in   1   sole clock; all logic on posedge
//  sdram_reset    in   1   synchronous, active-high reset
//  address        in   25  start word address; bits above MEM_ADDR_BITS ignored
//  access_num     in   10  burst length in words; 0 treated as 1
//  data_in        in   16  write data, consumed on each write_flag cycle
//  data_out       out  16  read data, valid on each read_flag cycle
//  write_request  in   1   initiator write request, level
//  read_request   in   1   initiator read request, level
//  sdram_ldqm     in   1   1 = mask data_in[7:0] on writes
//  sdram_udqm     in   1   1 = mask data_in[15:8] on writes
//  write_flag     out  1   high for exactly N cycles while write words are taken
//  read_flag      out  1   high for exactly N cycles while read words are presented
//  idle           out  1   high only in IDLE; ready to accept a request
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset values: state=IDLE, idle=1, write_flag=0, read_flag=0, data_out=0, counters=0.
//  - Memory array is not cleared by reset.
//  - States: IDLE, W_LAT, WRITE, R_LAT, READ, RECOVER.
//  - IDLE
//    - A request is sampled each cycle. write_request wins if both are high.
//    - On accept: latch address[MEM_ADDR_BITS-1:0], N = (access_num==0) ? 1 : access_num, and masks.
//    - Then go to W_LAT or R_LAT. idle drops on the cycle after the accept edge.
//  - W_LAT / R_LAT: count WRITE_LATENCY / READ_LATENCY cycles, then enter WRITE / READ.
//  - WRITE
//    - write_flag=1 for N cycles.
//    - Each flagged cycle writes data_in to mem[ptr] with per-byte masks sampled that cycle, then ptr++.
//  - READ
//    - read_flag=1 for N cycles; data_out = mem[ptr] registered and aligned with read_flag, ptr++.
//    - R_LAT provides the BRAM prefetch slot.
//    - data_out holds the last word after the burst.
//  - ptr wraps modulo 2**MEM_ADDR_BITS; no error on wrap.
//  - RECOVER: flags low, idle low, for RECOVERY cycles, then IDLE with idle=1.
//  - Request rules
//    - Once accepted, an access is committed. Dropping the request mid-latency or mid-burst does not abort it.
//    - A request still high when IDLE is re-entered is treated as a new access.
//    - The initiator is expected to drop the request on seeing a flag.
//  - No back-to-back overlap: a new request is never accepted outside IDLE.
//  - Reset mid-operation: next edge forces IDLE, flags 0.
//    - Words already written stay written; the rest of the burst is abandoned.
//  - write_flag and read_flag are never high together. idle is never high with either flag.
// TESTING
//  - Single write then read: write addr 0x00123, data 0xBEEF, N=1, masks 0.
//    - write_flag high 1 cycle, WRITE_LATENCY cycles after accept.
//    - Readback gives read_flag 1 cycle with data_out=0xBEEF.
//  - Byte masks: mem[0x10]=0x1234, then write 0xABCD with ldqm=1.
//    - Readback 0xAB34. With udqm=1 instead -> 0x12CD.
//  - Burst: write N=4 at 0xFFFE, data 1,2,3,4 (wraps to 0x0000/0x0001).
//    - write_flag high 4 cycles. Read N=4 at 0xFFFE -> 1,2,3,4 on consecutive read_flag cycles.
//  - Handshake: read request dropped 1 cycle after accept -> burst still completes.
//    - idle returns exactly RECOVERY cycles after the last flag.
//    - Both requests high in IDLE -> write performed.
//  - access_num=0 -> exactly 1 flag cycle.
//  - Reset during the 2nd cycle of an N=8 write burst.
//    - Next cycle: idle=1, write_flag=0.
//    - Only word 0 (and 1 if its cycle completed) is changed in memory.

Source files
------------

// File: rtl/kf_bram_responder.sv
// Block-RAM target speaking the KFSDRAM request/flag/idle protocol.
// Single-clock, synchronous-reset, single or burst word access.
module kf_bram_responder #(
  parameter int MEM_ADDR_BITS = 16,
  parameter int WRITE_LATENCY = 2,
  parameter int READ_LATENCY  = 3,
  parameter int RECOVERY      = 2
) (
  input  logic        sdram_clock,
  input  logic        sdram_reset,
  input  logic [24:0] address,
  input  logic [9:0]  access_num,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        write_request,
  input  logic        read_request,
  input  logic        sdram_ldqm,
  input  logic        sdram_udqm,
  output logic        write_flag,
  output logic        read_flag,
  output logic        idle
);

  localparam int DEPTH = 2 ** MEM_ADDR_BITS;
  localparam int CW    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_LAT,
    S_WRITE,
    S_R_LAT,
    S_READ,
    S_RECOVER
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [9:0]               rem_q, rem_d;
  logic [MEM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                     write_flag_q, write_flag_d;
  logic                     read_flag_q, read_flag_d;
  logic                     idle_q, idle_d;
  logic                     wr_en, rd_en;
  logic [15:0]              data_out_q;
  logic [15:0]              mem [DEPTH];
  logic                     unused_addr;

  assign unused_addr = ^address[24:MEM_ADDR_BITS];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    ptr_d        = ptr_q;
    write_flag_d = 1'b0;
    read_flag_d  = 1'b0;
    idle_d       = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idle_d = 1'b1;
        if (write_request || read_request) begin
          idle_d = 1'b0;
          ptr_d  = address[MEM_ADDR_BITS-1:0];
          rem_d  = (access_num == 10'd0) ? 10'd1 : access_num;
          if (write_request) begin
            state_d = S_W_LAT;
            cnt_d   = CW'(WRITE_LATENCY - 1);
          end else begin
            state_d = S_R_LAT;
            cnt_d   = CW'(READ_LATENCY - 1);
          end
        end
      end
      S_W_LAT: begin
        if (cnt_q == '0) begin
          state_d      = S_WRITE;
          write_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + MEM_ADDR_BITS'(1);
        if (rem_q == 10'd1) begin
          state_d = S_RECOVER;
          cnt_d   = CW'(RECOVERY - 1);
        end else begin
          rem_d        = rem_q - 10'd1;
          write_flag_d = 1'b1;
        end
      end
      // last latency cycle fetches word 0 so it lands with the first flag
      S_R_LAT: begin
        if (cnt_q == '0) begin
          state_d     = S_READ;
          read_flag_d = 1'b1;
          rd_en       = 1'b1;
          ptr_d       = ptr_q + MEM_ADDR_BITS'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_READ: begin
        if (rem_q == 10'd1) begin
          state_d = S_RECOVER;
          cnt_d   = CW'(RECOVERY - 1);
        end else begin
          rem_d       = rem_q - 10'd1;
          read_flag_d = 1'b1;
          rd_en       = 1'b1;
          ptr_d       = ptr_q + MEM_ADDR_BITS'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          idle_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idle_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sdram_clock) begin
    if (sdram_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      ptr_q        <= '0;
      write_flag_q <= 1'b0;
      read_flag_q  <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      ptr_q        <= ptr_d;
      write_flag_q <= write_flag_d;
      read_flag_q  <= read_flag_d;
      idle_q       <= idle_d;
    end
  end

  // array is deliberately not reset; a reset edge blocks the pending word
  always_ff @(posedge sdram_clock) begin
    if (wr_en && !sdram_reset) begin
      if (!sdram_ldqm) mem[ptr_q][7:0]  <= data_in[7:0];
      if (!sdram_udqm) mem[ptr_q][15:8] <= data_in[15:8];
    end
  end

  always_ff @(posedge sdram_clock) begin
    if (sdram_reset) begin
      data_out_q <= '0;
    end else if (rd_en) begin
      data_out_q <= mem[ptr_q];
    end
  end

  assign data_out   = data_out_q;
  assign write_flag = write_flag_q;
  assign read_flag  = read_flag_q;
  assign idle       = idle_q;

  a_flags_excl: assert property (
    @(posedge sdram_clock) !(write_flag_q && read_flag_q));
  a_idle_excl: assert property (
    @(posedge sdram_clock) !(idle_q && (write_flag_q || read_flag_q)));

endmodule

// File: tb/tb_kf_bram_responder.sv
// Bench for kf_bram_responder: directed cases plus random bursts
// checked against a word-array memory model and protocol timing.
module tb_kf_bram_responder;

  localparam int WL = 2;
  localparam int RL = 3;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] address = '0;
  logic [9:0]  access_num = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        write_request = 1'b0;
  logic        read_request = 1'b0;
  logic        ldqm = 1'b0;
  logic        udqm = 1'b0;
  logic        write_flag, read_flag, idle;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] model [65536];
  logic [15:0] wbuf [1024];

  kf_bram_responder #(
    .MEM_ADDR_BITS(16),
    .WRITE_LATENCY(WL),
    .READ_LATENCY(RL),
    .RECOVERY(RC)
  ) dut (
    .sdram_clock(clk),
    .sdram_reset(rst),
    .address(address),
    .access_num(access_num),
    .data_in(data_in),
    .data_out(data_out),
    .write_request(write_request),
    .read_request(read_request),
    .sdram_ldqm(ldqm),
    .sdram_udqm(udqm),
    .write_flag(write_flag),
    .read_flag(read_flag),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [15:0] d,
                             input bit lm, input bit um);
    if (!lm) model[a][7:0]  = d[7:0];
    if (!um) model[a][15:8] = d[15:8];
  endtask

  // one full access from IDLE to IDLE, checking every cycle
  task automatic run_access(input bit wr, input bit both,
                            input logic [24:0] addr, input logic [9:0] num,
                            input bit lm, input bit um, input bit drop_early);
    int n, lat, tot, k, w;
    bit fl;
    logic [15:0] a;
    n   = (num == 10'd0) ? 1 : int'(num);
    lat = wr ? WL : RL;
    tot = lat + n + RC + 1;
    w = 0;
    while (idle !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", 16'(idle), 16'(1));
    address       = addr;
    access_num    = num;
    ldqm          = lm;
    udqm          = um;
    write_request = wr || both;
    read_request  = !wr || both;
    for (int j = 1; j <= tot; j++) begin
      @(negedge clk);
      if (drop_early || j > lat) begin
        write_request = 1'b0;
        read_request  = 1'b0;
      end
      fl = (j > lat) && (j <= lat + n);
      k  = j - lat - 1;
      check("wflag", 16'(write_flag), 16'(wr && fl));
      check("rflag", 16'(read_flag), 16'(!wr && fl));
      check("idle", 16'(idle), 16'(j == tot));
      if (fl) begin
        a = addr[15:0] + 16'(k);
        if (wr) begin
          data_in = wbuf[k];
          model_write(a, wbuf[k], lm, um);
        end else begin
          check("rdata", data_out, model[a]);
        end
      end
    end
    if (!wr) check("rhold", data_out, model[addr[15:0] + 16'(n - 1)]);
    ldqm = 1'b0;
    udqm = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    logic [9:0]  num;
    bit          lm, um;

    repeat (3) @(negedge clk);
    check("rst_idle", 16'(idle), 16'(1));
    check("rst_wflag", 16'(write_flag), 16'(0));
    check("rst_rflag", 16'(read_flag), 16'(0));
    check("rst_dout", data_out, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 16'(idle), 16'(1));

    // single write / read
    wbuf[0] = 16'hBEEF;
    run_access(1, 0, 25'h00123, 10'd1, 0, 0, 0);
    run_access(0, 0, 25'h00123, 10'd1, 0, 0, 0);

    // byte masks
    wbuf[0] = 16'h1234;
    run_access(1, 0, 25'h10, 10'd1, 0, 0, 0);
    wbuf[0] = 16'hABCD;
    run_access(1, 0, 25'h10, 10'd1, 1, 0, 0);
    run_access(0, 0, 25'h10, 10'd1, 0, 0, 0);
    check("ldqm_model", model[16'h10], 16'hAB34);
    wbuf[0] = 16'h1234;
    run_access(1, 0, 25'h10, 10'd1, 0, 0, 0);
    wbuf[0] = 16'hABCD;
    run_access(1, 0, 25'h10, 10'd1, 0, 1, 0);
    run_access(0, 0, 25'h10, 10'd1, 0, 0, 0);
    check("udqm_model", model[16'h10], 16'h12CD);

    // wrapping burst; read uses junk upper address bits
    for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
    run_access(1, 0, 25'h0FFFE, 10'd4, 0, 0, 0);
    run_access(0, 0, 25'h1AFFFE, 10'd4, 0, 0, 0);
    check("wrap0", model[16'h0000], 16'h0003);
    // request dropped right after accept still completes
    run_access(0, 0, 25'h0FFFE, 10'd4, 0, 0, 1);

    // both requests: write wins
    wbuf[0] = 16'h5A5A;
    run_access(1, 1, 25'h40, 10'd1, 0, 0, 0);
    run_access(0, 0, 25'h40, 10'd1, 0, 0, 0);

    // access_num = 0 acts as 1
    wbuf[0] = 16'hC0DE;
    run_access(1, 0, 25'h50, 10'd0, 0, 0, 0);
    run_access(0, 0, 25'h50, 10'd0, 0, 0, 0);

    // reset in the 2nd flag cycle of an 8-word write
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h1000 + 16'(i);
    run_access(1, 0, 25'h200, 10'd8, 0, 0, 0);
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h2000 + 16'(i);
    address       = 25'h200;
    access_num    = 10'd8;
    write_request = 1'b1;
    for (int j = 1; j <= WL + 2; j++) begin
      @(negedge clk);
      if (j > WL) begin
        write_request = 1'b0;
        check("rst_burst_wflag", 16'(write_flag), 16'(1));
      end
      if (j == WL + 1) begin
        data_in = wbuf[0];
        model_write(16'h200, wbuf[0], 0, 0);
      end
      if (j == WL + 2) begin
        data_in = wbuf[1];
        rst     = 1'b1;
      end
    end
    @(negedge clk);
    check("mid_rst_idle", 16'(idle), 16'(1));
    check("mid_rst_wflag", 16'(write_flag), 16'(0));
    check("mid_rst_rflag", 16'(read_flag), 16'(0));
    rst = 1'b0;
    run_access(0, 0, 25'h200, 10'd8, 0, 0, 0);

    // random bursts: plain write, masked overwrite, readback
    for (int it = 0; it < 20; it++) begin
      base = 16'($urandom_range(0, 65535));
      num  = 10'($urandom_range(0, 8));
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      run_access(1, 0, {9'h0, base}, num, 0, 0, 0);
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      lm = 1'($urandom);
      um = 1'($urandom);
      run_access(1, 0, {9'h0, base}, num, lm, um, 0);
      run_access(0, 0, {9'h0, base}, num, 0, 0, it[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
